// File: rtl/bram2ip.sv
// Single-port byte-writable block RAM with a configurable read pipeline,
// selectable write-collision behaviour and saturating access counters.
module bram2ip #(
  parameter int    MEM_WIDTH    = 64,
  parameter int    MEM_SIZE     = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string WRITE_MODE   = "READ_FIRST"
) (
  input  logic                        bram_clk,
  input  logic                        bram_rst,
  input  logic                        bram_en,
  input  logic [MEM_WIDTH/8-1:0]      bram_we,
  input  logic [$clog2(MEM_SIZE)-1:0] bram_addr,
  input  logic [MEM_WIDTH-1:0]        bram_din,
  output logic [MEM_WIDTH-1:0]        bram_dout,
  output logic                        bram_dout_valid,
  output logic [31:0]                 wr_cnt,
  output logic [31:0]                 rd_cnt,
  output logic [15:0]                 oor_cnt
);

  localparam int          NB       = MEM_WIDTH / 8;
  localparam int          AW       = $clog2(MEM_SIZE);
  localparam logic [AW:0] SIZE_EXT = (AW + 1)'(MEM_SIZE);
  localparam bit          IS_WF    = (WRITE_MODE == "WRITE_FIRST");
  localparam bit          IS_NC    = (WRITE_MODE == "NO_CHANGE");

  logic                 in_range;
  logic                 any_we;
  logic                 acc_wr;
  logic                 acc_rd;
  logic                 oor_acc;
  logic                 oor_rd;
  logic [MEM_WIDTH-1:0] old_word;
  logic [MEM_WIDTH-1:0] merged_word;

  // Extra top bit keeps the compare correct when MEM_SIZE is a power of two.
  assign in_range = ({1'b0, bram_addr} < SIZE_EXT);
  assign any_we   = |bram_we;
  assign acc_wr   = bram_en && any_we && in_range;
  assign acc_rd   = bram_en && !any_we && in_range;
  assign oor_acc  = bram_en && !in_range;
  assign oor_rd   = oor_acc && !any_we;

  // One byte-wide array per lane so each byte enable owns its own storage.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_SIZE] = '{default: 8'h00};

      always_ff @(posedge bram_clk) begin
        if (!bram_rst && acc_wr && bram_we[gi]) begin
          lane_mem[bram_addr] <= bram_din[8*gi +: 8];
        end
      end

      assign old_word[8*gi +: 8]    = lane_mem[bram_addr];
      assign merged_word[8*gi +: 8] = bram_we[gi] ? bram_din[8*gi +: 8] : lane_mem[bram_addr];
    end
  endgenerate

  logic [MEM_WIDTH-1:0] data_reg  [READ_LATENCY];
  logic                 valid_reg [READ_LATENCY];
  logic [MEM_WIDTH-1:0] data_next;
  logic                 valid_next;

  always_comb begin
    data_next  = data_reg[0];
    valid_next = 1'b0;
    if (acc_rd) begin
      data_next  = old_word;
      valid_next = 1'b1;
    end else if (acc_wr && !IS_NC) begin
      data_next  = IS_WF ? merged_word : old_word;
      valid_next = 1'b1;
    end else if (oor_rd) begin
      data_next  = '0;
    end
  end

  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      data_reg[0]  <= '0;
      valid_reg[0] <= 1'b0;
    end else begin
      data_reg[0]  <= data_next;
      valid_reg[0] <= valid_next;
    end
  end

  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
      always_ff @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else begin
          data_reg[gi]  <= data_reg[gi-1];
          valid_reg[gi] <= valid_reg[gi-1];
        end
      end
    end
  endgenerate

  assign bram_dout       = data_reg[READ_LATENCY-1];
  assign bram_dout_valid = valid_reg[READ_LATENCY-1];

  logic [31:0] wr_cnt_reg;
  logic [31:0] rd_cnt_reg;
  logic [15:0] oor_cnt_reg;

  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      oor_cnt_reg <= '0;
    end else begin
      if (acc_wr && (wr_cnt_reg != 32'hFFFF_FFFF)) begin
        wr_cnt_reg <= wr_cnt_reg + 32'd1;
      end
      if (acc_rd && (rd_cnt_reg != 32'hFFFF_FFFF)) begin
        rd_cnt_reg <= rd_cnt_reg + 32'd1;
      end
      if (oor_acc && (oor_cnt_reg != 16'hFFFF)) begin
        oor_cnt_reg <= oor_cnt_reg + 16'd1;
      end
    end
  end

  assign wr_cnt  = wr_cnt_reg;
  assign rd_cnt  = rd_cnt_reg;
  assign oor_cnt = oor_cnt_reg;

endmodule

// File: doc/bram2ip.md
BRAM2IP -- requirements
Module: bram2ip

Interface
REQ-001 Parameter MEM_WIDTH, default 64: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter MEM_SIZE, default 1024: depth in words; need not be a power of 2.
REQ-003 Parameter READ_LATENCY, default 1: cycles from read access to data; legal values 1..3.
REQ-004 Parameter WRITE_MODE, default "READ_FIRST": collision behaviour; legal values "READ_FIRST", "WRITE_FIRST", "NO_CHANGE".
REQ-005 Port bram_clk  input  1: single clock; all logic on its rising edge.
REQ-006 Port bram_rst  input  1: reset, asynchronous and active-high.
REQ-007 Port bram_en  input  1: access enable.
REQ-008 Port bram_we  input  MEM_WIDTH/8: byte write enables; bit i covers data bits [8i+7:8i].
REQ-009 Port bram_addr  input  $clog2(MEM_SIZE): word address.
REQ-010 Port bram_din  input  MEM_WIDTH: write data.
REQ-011 Port bram_dout  output  MEM_WIDTH: read data.
REQ-012 Port bram_dout_valid  output  1: bram_dout carries the data of a completed read this cycle.
REQ-013 Port wr_cnt  output  32: count of accepted writes.
REQ-014 Port rd_cnt  output  32: count of accepted reads.
REQ-015 Port oor_cnt  output  16: count of out-of-range accesses.

Function
REQ-016 Access classes: en=1 and we!=0 is a write; en=1 and we=0 is a read; en=0 is idle, with no state change other than pipeline advance.
REQ-017 Write: only the bytes with we[i]=1 SHALL update at the clock edge; the other bytes keep their old value.
REQ-018 Stage-1 output register SHALL load only on an in-range access; it holds otherwise, except under NO_CHANGE writes (REQ-021).
REQ-019 Stages 2..READ_LATENCY SHALL copy the previous stage every cycle; bram_dout is the last stage.
REQ-020 Stage-1 load value for a read: the array word at the address. Data appears READ_LATENCY edges after the access edge.
REQ-021 Stage-1 load value for a write, by WRITE_MODE: READ_FIRST loads the pre-write word; WRITE_FIRST loads the merged post-write word; NO_CHANGE leaves stage 1 unchanged.
REQ-022 A valid shift register SHALL track the data stages. Stage-1 valid = in-range read, or in-range write in READ_FIRST/WRITE_FIRST mode; valid is 0 when idle or out-of-range.
REQ-023 bram_dout_valid SHALL be the last-stage valid bit; bram_dout holds its last value when valid is 0.
REQ-024 Back-to-back accesses SHALL be accepted every cycle with no stall; read-after-write to the same address on the next cycle SHALL return the new data.
REQ-025 Out-of-range (addr >= MEM_SIZE): writes SHALL be ignored; reads SHALL load zero into stage 1 with valid 0; oor_cnt increments by 1.
REQ-026 wr_cnt increments by 1 per in-range write and rd_cnt by 1 per in-range read. Both saturate at 0xFFFFFFFF; oor_cnt saturates at 0xFFFF.
REQ-027 Array contents SHALL initialise to all zeros (simulation and bitstream init).

Reset
REQ-028 bram_rst=1 SHALL asynchronously clear all data stages, the valid stages, bram_dout, bram_dout_valid, wr_cnt, rd_cnt and oor_cnt to 0.
REQ-029 Reset SHALL NOT modify array contents. An access sampled on an edge where bram_rst=1 SHALL be ignored.
REQ-030 Reset asserted mid-read SHALL discard in-flight data; bram_dout_valid SHALL be 0 on the first edge after deassertion.

Verification
REQ-031 Byte write: with W=64, write 0x1122334455667788 to addr 5 with we=0xFF, then 0xAAAA... with we=0x0F, then read addr 5 -> 0x11223344AAAAAAAA; with READ_LATENCY=2, valid is high exactly 2 edges after the read edge.
REQ-032 Collision: addr 7 holds 0x1; write 0x2 to addr 7 -> READ_FIRST outputs 0x1 (valid=1), WRITE_FIRST outputs 0x2 (valid=1), NO_CHANGE keeps the previous dout with valid=0.
REQ-033 Streaming: reads of addr 0..15 on consecutive cycles -> 16 consecutive valid outputs in address order; rd_cnt=16.
REQ-034 Out-of-range: MEM_SIZE=1000, write to addr 1020 then read addr 1020 -> array unchanged, valid=0, oor_cnt=2, wr_cnt and rd_cnt unchanged.
REQ-035 Reset: pulse bram_rst between a read edge and its data (READ_LATENCY=3) -> outputs and counters go to 0 immediately, no valid pulse follows; a later read of the previously written address returns the written data.
REQ-036 Saturation: force wr_cnt to 0xFFFFFFFE, perform 3 writes -> wr_cnt=0xFFFFFFFF.
